sd_sector_server: RTL and testbench

Responder side of the core's SD sector-buffer protocol. It accepts `sd_rd`/`sd_wr` sector requests from the save-RAM backup controller, raises `sd_ack`, and streams one 512-byte sector between the core's sector buffer and a local byte-wide backing store. Reads fill the buffer; writes drain it. It sits between the save-RAM controller and a backing memory port (BRAM or SDRAM arbiter), standing in for the host SD path in standalone and simulation builds.

---
 rtl/sd_sector_server.sv | 159 +++++++++++++++
 tb/tb_sd_sector_server.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_sector_server.sv
// Responder for the SD sector-buffer protocol: serves one 512-byte sector per
// sd_rd/sd_wr request between the core's sector buffer and a byte-wide store.
module sd_sector_server #(
  parameter int          LBA_BITS = 4,
  parameter int          BUF_LAT  = 1,
  parameter logic [7:0]  FILL     = 8'hFF
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [31:0]           sd_lba,
  input  logic                  sd_rd,
  input  logic                  sd_wr,
  output logic                  sd_ack,
  output logic [8:0]            sd_buff_addr,
  output logic [7:0]            sd_buff_dout,
  output logic                  sd_buff_wr,
  input  logic [7:0]            sd_buff_din,
  output logic [LBA_BITS+8:0]   mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din,
  input  logic                  mem_ready,
  output logic                  range_err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_STB  = 3'd2;
  localparam logic [2:0] WR_ADDR = 3'd3;
  localparam logic [2:0] WR_LAT  = 3'd4;
  localparam logic [2:0] WR_REQ  = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  localparam logic [7:0] LAT_LAST = 8'(BUF_LAT - 1);

  logic [2:0]          state_q, state_d;
  logic [LBA_BITS-1:0] lba_q, lba_d;
  logic                oor_q, oor_d;
  logic [8:0]          k_q, k_d;
  logic [7:0]          lat_q, lat_d;
  logic [8:0]          buff_addr_q, buff_addr_d;
  logic [7:0]          buff_dout_q, buff_dout_d;
  logic [7:0]          mem_dout_q, mem_dout_d;
  logic                range_err_q, range_err_d;
  logic                lba_oor;
  logic                byte_done;

  assign lba_oor = (sd_lba >> LBA_BITS) != 32'd0;
  // Out-of-range sectors never touch the store, so they complete at once.
  assign byte_done = oor_q || mem_ready;

  // NOTE: every _d gets its _q value first so no path through the case can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    lba_d       = lba_q;
    oor_d       = oor_q;
    k_d         = k_q;
    lat_d       = lat_q;
    buff_addr_d = buff_addr_q;
    buff_dout_d = buff_dout_q;
    mem_dout_d  = mem_dout_q;
    range_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_d       = sd_lba[LBA_BITS-1:0];
          oor_d       = lba_oor;
          range_err_d = lba_oor;
          k_d         = 9'd0;
          if (sd_rd) begin
            state_d = RD_REQ;
          end else begin
            buff_addr_d = 9'd0;
            state_d     = WR_ADDR;
          end
        end
      end
      RD_REQ: begin
        if (byte_done) begin
          buff_dout_d = oor_q ? FILL : mem_din;
          buff_addr_d = k_q;
          state_d     = RD_STB;
        end
      end
      RD_STB: begin
        if (k_q == 9'd511) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 9'd1;
          state_d = RD_REQ;
        end
      end
      WR_ADDR: begin
        lat_d   = 8'd0;
        state_d = WR_LAT;
      end
      WR_LAT: begin
        if (lat_q == LAT_LAST) begin
          mem_dout_d = sd_buff_din;
          state_d    = WR_REQ;
        end else begin
          lat_d = lat_q + 8'd1;
        end
      end
      WR_REQ: begin
        if (byte_done) begin
          if (k_q == 9'd511) begin
            state_d = DONE;
          end else begin
            k_d         = k_q + 9'd1;
            buff_addr_d = k_q + 9'd1;
            state_d     = WR_ADDR;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lba_q       <= '0;
      oor_q       <= 1'b0;
      k_q         <= 9'd0;
      lat_q       <= 8'd0;
      buff_addr_q <= 9'd0;
      buff_dout_q <= 8'd0;
      mem_dout_q  <= 8'd0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      oor_q       <= oor_d;
      k_q         <= k_d;
      lat_q       <= lat_d;
      buff_addr_q <= buff_addr_d;
      buff_dout_q <= buff_dout_d;
      mem_dout_q  <= mem_dout_d;
      range_err_q <= range_err_d;
    end
  end

  assign sd_ack       = (state_q != IDLE) && (state_q != DONE);
  assign sd_buff_wr   = (state_q == RD_STB);
  assign sd_buff_addr = buff_addr_q;
  assign sd_buff_dout = buff_dout_q;
  assign mem_addr     = {lba_q, k_q};
  assign mem_rd       = (state_q == RD_REQ) && !oor_q;
  assign mem_wr       = (state_q == WR_REQ) && !oor_q;
  assign mem_dout     = mem_dout_q;
  assign range_err    = range_err_q;

endmodule

// File: tb/tb_sd_sector_server.sv
// Directed bench for sd_sector_server: byte-wide store model with optional
// wait states, a 1-cycle-latency sector buffer model and a strobe monitor.
module tb_sd_sector_server;

  logic        clk_sys;
  logic        reset;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [12:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_ready;
  logic        range_err;

  sd_sector_server dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack),
    .sd_buff_addr (sd_buff_addr),
    .sd_buff_dout (sd_buff_dout),
    .sd_buff_wr   (sd_buff_wr),
    .sd_buff_din  (sd_buff_din),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_dout     (mem_dout),
    .mem_din      (mem_din),
    .mem_ready    (mem_ready),
    .range_err    (range_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Backing store model, owned entirely by this process.
  logic [7:0] store [0:8191];
  bit         init_done = 1'b0;
  bit         wait_en   = 1'b0;
  int         wcnt      = 0;
  int         wtarget   = 0;
  int         memreq_tot = 0;
  int         stab_err_tot = 0;
  logic [12:0] held_addr;
  logic [7:0]  held_dout;

  initial begin
    mem_ready = 1'b0;
    mem_din   = 8'd0;
  end

  always @(negedge clk_sys) begin : mem_model
    logic [12:0] a13;
    if (!init_done) begin
      for (int i = 0; i < 8192; i++) begin
        a13 = 13'(i);
        store[i] = a13[7:0] ^ {4'b0, a13[12:9]};
      end
      init_done = 1'b1;
    end
    if (mem_rd || mem_wr) begin
      memreq_tot++;
      if (wcnt == 0) begin
        held_addr = mem_addr;
        held_dout = mem_dout;
      end else if (mem_addr != held_addr || (mem_wr && mem_dout != held_dout)) begin
        stab_err_tot++;
      end
      if (wcnt >= wtarget) begin
        mem_ready = 1'b1;
        mem_din   = store[mem_addr];
        if (mem_wr) store[mem_addr] = mem_dout;
        wcnt    = 0;
        wtarget = wait_en ? int'($urandom_range(0, 5)) : 0;
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt      = 0;
    end
  end

  // Sector buffer read port with one cycle of latency.
  logic [7:0] wpat = 8'hA5;
  always @(posedge clk_sys) sd_buff_din <= wpat ^ sd_buff_addr[7:0];

  // Monitor of buffer strobes, ack gaps and range errors.
  logic [7:0] rd_buf [0:511];
  int   strobes_tot = 0;
  int   order_err_tot = 0;
  int   rerr_tot = 0;
  int   low_run = 0;
  int   last_gap = 0;
  logic [8:0] exp_a = 9'd0;
  logic ack_prev = 1'b0;

  always @(negedge clk_sys) begin
    if (sd_buff_wr) begin
      if (sd_buff_addr != exp_a) order_err_tot++;
      exp_a = exp_a + 9'd1;
      rd_buf[sd_buff_addr] = sd_buff_dout;
      strobes_tot++;
    end
    if (!sd_ack) exp_a = 9'd0;
    if (range_err) rerr_tot++;
    if (sd_ack && !ack_prev) last_gap = low_run;
    if (!sd_ack) low_run++;
    else low_run = 0;
    ack_prev = sd_ack;
  end

  function automatic int read_errs(input logic [3:0] lba, input bit oor);
    int e = 0;
    for (int k = 0; k < 512; k++) begin
      if (oor) begin
        if (rd_buf[k] !== 8'hFF) e++;
      end else if (rd_buf[k] !== store[{lba, 9'(k)}]) e++;
    end
    return e;
  endfunction

  function automatic int write_errs(input logic [3:0] lba, input logic [7:0] p);
    logic [8:0] k9;
    int e = 0;
    for (int k = 0; k < 512; k++) begin
      k9 = 9'(k);
      if (store[{lba, k9}] !== (p ^ k9[7:0])) e++;
    end
    return e;
  endfunction

  // Raises a request at the current negedge, drops it once sd_ack is seen,
  // and returns at the negedge where sd_ack is first low again.
  task automatic xfer(input string tag, input bit rd, input bit wr,
                      input logic [31:0] lba, output int cycles);
    int n = 0;
    sd_lba = lba;
    sd_rd  = rd;
    sd_wr  = wr;
    while (!sd_ack && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    check({tag, "_ack_rise"}, 32'(sd_ack), 32'd1);
    cycles = 0;
    while (sd_ack && cycles < 20000) begin
      cycles++;
      @(negedge clk_sys);
    end
    check({tag, "_ack_fall"}, 32'(sd_ack), 32'd0);
  endtask

  logic [7:0] snap [0:8191];
  int cyc, s0, o0, r0, m0, t0, errs, min_gap, bytes, n;

  initial begin
    reset  = 1'b1;
    sd_lba = 32'd0;
    sd_rd  = 1'b0;
    sd_wr  = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("reset_ack", 32'(sd_ack), 32'd0);
    check("reset_outs", 32'(|{sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
                              mem_rd, mem_wr, mem_dout, range_err}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // In-range read of sector 3, zero-wait memory.
    s0 = strobes_tot; o0 = order_err_tot; r0 = rerr_tot;
    xfer("rd3", 1'b1, 1'b0, 32'd3, cyc);
    check("rd3_cycles", cyc, 1024);
    check("rd3_strobes", strobes_tot - s0, 512);
    check("rd3_order", order_err_tot - o0, 0);
    check("rd3_data", read_errs(4'd3, 1'b0), 0);
    check("rd3_rerr", rerr_tot - r0, 0);
    check("rd3_byte0", 32'(rd_buf[0]), 32'h03);

    // In-range write of sector 15, buffer holds 0xA5^k.
    @(negedge clk_sys);
    s0 = strobes_tot;
    wpat = 8'hA5;
    xfer("wr15", 1'b0, 1'b1, 32'd15, cyc);
    check("wr15_cycles", cyc, 1536);
    check("wr15_data", write_errs(4'd15, 8'hA5), 0);
    check("wr15_no_strobe", strobes_tot - s0, 0);

    // Random memory wait states.
    wait_en = 1'b1;
    @(negedge clk_sys);
    t0 = stab_err_tot; o0 = order_err_tot;
    xfer("rdw", 1'b1, 1'b0, 32'd7, cyc);
    check("rdw_data", read_errs(4'd7, 1'b0), 0);
    check("rdw_order", order_err_tot - o0, 0);
    check("rdw_stable", stab_err_tot - t0, 0);
    check("rdw_slower", 32'(cyc > 1024), 32'd1);
    @(negedge clk_sys);
    wpat = 8'h3C;
    xfer("wrw", 1'b0, 1'b1, 32'd9, cyc);
    check("wrw_data", write_errs(4'd9, 8'h3C), 0);
    check("wrw_stable", stab_err_tot - t0, 0);
    wait_en = 1'b0;

    // Out-of-range read and write of sector 16.
    for (int i = 0; i < 8192; i++) snap[i] = store[i];
    @(negedge clk_sys);
    s0 = strobes_tot; r0 = rerr_tot; m0 = memreq_tot; o0 = order_err_tot;
    xfer("oor_rd", 1'b1, 1'b0, 32'd16, cyc);
    check("oor_rd_cycles", cyc, 1024);
    check("oor_rd_rerr", rerr_tot - r0, 1);
    check("oor_rd_strobes", strobes_tot - s0, 512);
    check("oor_rd_order", order_err_tot - o0, 0);
    check("oor_rd_fill", read_errs(4'd0, 1'b1), 0);
    check("oor_rd_memreq", memreq_tot - m0, 0);
    @(negedge clk_sys);
    r0 = rerr_tot; m0 = memreq_tot;
    xfer("oor_wr", 1'b0, 1'b1, 32'd16, cyc);
    check("oor_wr_cycles", cyc, 1536);
    check("oor_wr_rerr", rerr_tot - r0, 1);
    check("oor_wr_memreq", memreq_tot - m0, 0);
    errs = 0;
    for (int i = 0; i < 8192; i++) if (store[i] !== snap[i]) errs++;
    check("oor_wr_store", errs, 0);

    // Simultaneous requests: read wins.
    @(negedge clk_sys);
    s0 = strobes_tot; m0 = memreq_tot;
    xfer("both", 1'b1, 1'b1, 32'd1, cyc);
    check("both_strobes", strobes_tot - s0, 512);
    check("both_data", read_errs(4'd1, 1'b0), 0);

    // Sixteen back-to-back sector reads.
    @(negedge clk_sys);
    s0 = strobes_tot; o0 = order_err_tot;
    errs = 0; min_gap = 1000;
    for (int s = 0; s < 16; s++) begin
      xfer("b2b", 1'b1, 1'b0, 32'(s), cyc);
      errs += read_errs(4'(s), 1'b0);
      if (s > 0 && last_gap < min_gap) min_gap = last_gap;
    end
    bytes = strobes_tot - s0;
    check("b2b_bytes", bytes, 8192);
    check("b2b_data", errs, 0);
    check("b2b_order", order_err_tot - o0, 0);
    check("b2b_min_gap", min_gap, 2);

    // Reset during a read, then a clean sector.
    @(negedge clk_sys);
    s0 = strobes_tot;
    sd_lba = 32'd5;
    sd_rd  = 1'b1;
    n = 0;
    while (!sd_ack && n < 10) begin
      @(negedge clk_sys);
      n++;
    end
    sd_rd = 1'b0;
    n = 0;
    while ((strobes_tot - s0) < 200 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check("mid_reached_200", 32'((strobes_tot - s0) >= 200), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ack", 32'(sd_ack), 32'd0);
    check("mid_rst_outs", 32'(|{sd_buff_addr, sd_buff_dout, sd_buff_wr, mem_addr,
                                mem_rd, mem_wr, mem_dout, range_err}), 32'd0);
    s0 = strobes_tot;
    repeat (3) @(negedge clk_sys);
    check("mid_no_strobes", strobes_tot - s0, 0);
    reset = 1'b0;
    @(negedge clk_sys);
    s0 = strobes_tot; o0 = order_err_tot;
    xfer("post_rst", 1'b1, 1'b0, 32'd2, cyc);
    check("post_rst_cycles", cyc, 1024);
    check("post_rst_strobes", strobes_tot - s0, 512);
    check("post_rst_order", order_err_tot - o0, 0);
    check("post_rst_data", read_errs(4'd2, 1'b0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
